// File: rtl/free_list.sv
// rtl/free_list.sv - rename free list: circular FIFO of physical registers with head checkpoints for branch recovery.
module free_list #(
  parameter int NUM_PHYS_REGS  = 64,
  parameter int NUM_ARCH_REGS  = 32,
  parameter int PHYS_REG_WIDTH = 6,
  parameter int NUM_CKPT       = 4,
  parameter int DEPTH          = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc_req,
  output logic                          alloc_valid,
  output logic [PHYS_REG_WIDTH-1:0]     alloc_prd,
  input  logic                          free_valid,
  input  logic [PHYS_REG_WIDTH-1:0]     free_prd,
  input  logic                          ckpt_wen,
  input  logic [$clog2(NUM_CKPT)-1:0]   ckpt_tag,
  input  logic                          flush_valid,
  input  logic [$clog2(NUM_CKPT)-1:0]   flush_tag,
  output logic                          empty,
  output logic [PHYS_REG_WIDTH:0]       count,
  output logic                          overflow_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  logic [PHYS_REG_WIDTH-1:0] list_q [DEPTH];
  logic [PW-1:0]             ckpt_q [NUM_CKPT];
  logic [PW-1:0]             head_q, head_d, tail_q, tail_d;
  logic                      ovf_q, ovf_d;
  logic [AW:0]               used;
  logic                      full, enq, enq_ok;

  // Index wraps at DEPTH-1 (not necessarily a power of two); the MSB flips on each wrap.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) return {~p[AW], {AW{1'b0}}};
    return p + PW'(1);
  endfunction

  always_comb begin
    used = '0;
    if (tail_q[AW] == head_q[AW])
      used = {1'b0, tail_q[AW-1:0]} - {1'b0, head_q[AW-1:0]};
    else
      used = (AW+1)'(DEPTH) + {1'b0, tail_q[AW-1:0]} - {1'b0, head_q[AW-1:0]};
  end

  assign count        = (PHYS_REG_WIDTH+1)'(used);
  assign empty        = (used == '0);
  assign full         = (used == (AW+1)'(DEPTH));
  assign alloc_prd    = list_q[head_q[AW-1:0]];
  assign alloc_valid  = rst_n & alloc_req & ~empty & ~flush_valid;
  assign overflow_err = ovf_q;

  // p0 is hardwired and never returns; a full list only accepts a free alongside a dequeue.
  assign enq    = free_valid && (free_prd != '0);
  assign enq_ok = enq && (!full || alloc_valid);

  always_comb begin
    head_d = head_q;
    if (flush_valid)      head_d = ckpt_q[flush_tag];
    else if (alloc_valid) head_d = ptr_inc(head_q);
    tail_d = enq_ok ? ptr_inc(tail_q) : tail_q;
    ovf_d  = ovf_q | (enq & ~enq_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) list_q[i] <= PHYS_REG_WIDTH'(NUM_ARCH_REGS + i);
      for (int i = 0; i < NUM_CKPT; i++) ckpt_q[i] <= '0;
      head_q <= '0;
      tail_q <= {1'b1, {AW{1'b0}}};
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
      if (enq_ok) list_q[tail_q[AW-1:0]] <= free_prd;
      if (ckpt_wen && !flush_valid) ckpt_q[ckpt_tag] <= head_d;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed and random scoreboard bench for the rename free list.
module tb_free_list;

  logic       clk, rst_n, alloc_req, alloc_valid, free_valid, ckpt_wen, flush_valid;
  logic       empty, overflow_err;
  logic [5:0] alloc_prd, free_prd;
  logic [1:0] ckpt_tag, flush_tag;
  logic [6:0] count;

  free_list dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_prd(alloc_prd), .free_valid(free_valid), .free_prd(free_prd),
    .ckpt_wen(ckpt_wen), .ckpt_tag(ckpt_tag), .flush_valid(flush_valid),
    .flush_tag(flush_tag), .empty(empty), .count(count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int idx; int prd; } own_t;

  int   errors = 0;
  int   checks = 0;
  int   m_head, m_tail, m_mem[32], m_ck[4];
  bit   m_ckv[4];
  bit   m_ovf, m_grant;
  int   m_prd, wraps;
  int   exp_q[$];
  own_t owned[$];
  bit   held[64];
  logic       last_valid;
  logic [5:0] last_prd;
  logic [6:0] last_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_head = 0; m_tail = 32; m_ovf = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32 + i;
    for (int i = 0; i < 4; i++) begin m_ck[i] = 0; m_ckv[i] = 0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    alloc_req = 1'b1; free_valid = 1'b0; free_prd = '0; ckpt_wen = 1'b0;
    ckpt_tag = '0; flush_valid = 1'b0; flush_tag = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_count", count, 32);
    chk("rst_empty", empty, 0);
    chk("rst_alloc_valid", alloc_valid, 0);
    chk("rst_overflow", overflow_err, 0);
    chk("rst_alloc_prd", alloc_prd, 32);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    alloc_req = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit req, input bit fv, input int fp, input bit cw, input int ct,
                      input bit fl, input int ft);
    int cnt, nh;
    @(negedge clk);
    alloc_req = req; free_valid = fv; free_prd = fp[5:0];
    ckpt_wen = cw; ckpt_tag = ct[1:0]; flush_valid = fl; flush_tag = ft[1:0];
    #1;
    cnt     = m_tail - m_head;
    m_grant = req && (cnt > 0) && !fl;
    m_prd   = m_mem[m_head % 32];
    if (m_grant) exp_q.push_back(m_prd);
    chk("count", count, cnt);
    chk("empty", empty, cnt == 0);
    chk("alloc_valid", alloc_valid, m_grant);
    chk("overflow_err", overflow_err, m_ovf);
    if (alloc_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("alloc_prd_unexpected", alloc_prd, 0);
      else chk("alloc_prd", alloc_prd, exp_q.pop_front());
    end
    exp_q.delete();
    last_valid = alloc_valid; last_prd = alloc_prd; last_count = count;
    nh = fl ? m_ck[ft] : (m_grant ? m_head + 1 : m_head);
    if (m_grant && (m_head % 32) == 31) wraps++;
    if (fv && fp != 0) begin
      if (cnt == 32 && !m_grant) m_ovf = 1;
      else begin m_mem[m_tail % 32] = fp; m_tail++; end
    end
    if (cw && !fl) m_ck[ct] = nh;
    m_head = nh;
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b1; alloc_req = 1'b0; free_valid = 1'b0; free_prd = '0;
    ckpt_wen = 1'b0; ckpt_tag = '0; flush_valid = 1'b0; flush_tag = '0;
    wraps = 0;
    model_reset();

    // Overflow from the full reset state, and p0 frees being ignored.
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 7, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("ovf_set", last_valid === 1'b0 && overflow_err === 1'b1, 1);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    chk("ovf_sticky", overflow_err, 1);

    // Checkpoint with same-cycle alloc, then restore.
    do_reset();
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    chk("ckpt_cycle_prd", last_prd, 35);
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("flush_next_prd", last_prd, 36);
    chk("flush_count", last_count, 28);

    // Flush beats alloc; the same-cycle free still lands at the tail.
    step(1, 1, 5, 0, 0, 1, 1);
    chk("flush_alloc_blocked", last_valid, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("flush_free_count", last_count, 29);
    repeat (28) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("freed_5_reused", last_prd, 5);

    // Drain all 32 then alloc/free collision on empty.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      chk("drain_prd", last_prd, 32 + i);
      chk("drain_valid", last_valid, 1);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("drained_empty", empty, 1);
    chk("drained_count", last_count, 0);
    step(1, 1, 40, 0, 0, 0, 0);
    chk("empty_no_forward", last_valid, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("refill_valid", last_valid, 1);
    chk("refill_prd", last_prd, 40);

    // Random legal traffic: only frees older than every live checkpoint.
    do_reset();
    owned.delete();
    for (int i = 0; i < 64; i++) held[i] = (i < 32);
    wraps = 0;
    for (int c = 0; c < 1000; c++) begin
      int minck, fp, ct, ft, pre_head;
      bit req, fv, cw, fl;
      own_t e;
      minck = 1 << 30;
      for (int t = 0; t < 4; t++) if (m_ckv[t] && m_ck[t] < minck) minck = m_ck[t];
      req = ($urandom_range(0, 9) < 7);
      fv = 0; fp = 0;
      if (owned.size() > 0 && owned[0].idx < minck && $urandom_range(0, 9) < 6) begin
        fv = 1; fp = owned[0].prd;
      end else if ($urandom_range(0, 19) == 0) fv = 1;
      fl = 0; ft = 0;
      if ($urandom_range(0, 39) == 0) begin ft = $urandom_range(0, 3); fl = m_ckv[ft]; end
      cw = ($urandom_range(0, 99) < 15);
      ct = $urandom_range(0, 3);
      if (!cw && $urandom_range(0, 9) < 3) m_ckv[$urandom_range(0, 3)] = 0;
      pre_head = m_head;
      step(req, fv, fp, cw, ct, fl, ft);
      if (fv && fp != 0) begin void'(owned.pop_front()); held[fp] = 0; end
      if (fl) begin
        while (owned.size() > 0 && owned[owned.size()-1].idx >= m_head) begin
          held[owned[owned.size()-1].prd] = 0;
          void'(owned.pop_back());
        end
        for (int t = 0; t < 4; t++) if (m_ckv[t] && m_ck[t] > m_head) m_ckv[t] = 0;
      end else if (m_grant) begin
        if (last_valid === 1'b1) chk("no_duplicate", held[last_prd], 0);
        held[m_prd] = 1;
        e.idx = pre_head; e.prd = m_prd;
        owned.push_back(e);
      end
      if (cw && !fl) m_ckv[ct] = 1;
      chk("count_range", count <= 7'd32, 1);
    end
    chk("wrap_seen", wraps >= 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
